// File: rtl/syscall_ctrl_if.sv
// syscall_ctrl_if
//   Bundles the signals between the syscall sequencer and its surroundings:
//   the decode-side request (sys_req/regv/rega), the borrowed instruction
//   memory read port (mem_addr/mem_rdata/mem_sel), the two console sinks
//   (char_* and int_* valid/ready pairs) and pipeline status (stall/done/halt).
//   master : the sequencer itself (drives mem_*, char_*, int_*, stall, done, halt)
//   slave  : the pipeline/memory/console side (drives requests, read data, readies)
interface syscall_ctrl_if #(
  parameter int ADDR_W = 30
);
  logic              sys_req;
  logic [31:0]       regv;
  logic [31:0]       rega;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_sel;
  logic              char_valid;
  logic [7:0]        char_data;
  logic              char_ready;
  logic              int_valid;
  logic [31:0]       int_data;
  logic              int_ready;
  logic              stall;
  logic              done;
  logic              halt;

  modport master (
    input  sys_req, regv, rega, mem_rdata, char_ready, int_ready,
    output mem_addr, mem_sel, char_valid, char_data, int_valid, int_data,
           stall, done, halt
  );

  modport slave (
    output sys_req, regv, rega, mem_rdata, char_ready, int_ready,
    input  mem_addr, mem_sel, char_valid, char_data, int_valid, int_data,
           stall, done, halt
  );
endinterface

// File: rtl/syscall_ctrl.sv
// syscall_ctrl
//   Hardware sequencer for the print-int (1), print-string (4) and exit (10)
//   system-call services. A syscall pulse from decode stalls the pipeline;
//   print-string borrows the instruction memory read port to walk a
//   NUL-terminated string one word at a time and streams its bytes (LSB byte
//   first) plus a trailing newline to the char sink. Exit raises a sticky halt.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     bus   : syscall_ctrl_if.master (request, memory port, sinks, status)
//   Parameters:
//     ADDR_W    : word-address width of the memory read port
//     MAX_WORDS : words read per string before forced termination
module syscall_ctrl #(
  parameter int ADDR_W    = 30,
  parameter int MAX_WORDS = 64
) (
  input logic            clk,
  input logic            rst_n,
  syscall_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    PUT_INT,
    FETCH,
    EMIT,
    NEWLINE,
    DONE,
    HALT
  } state_t;

  localparam logic [16:0]       MAXW = 17'(MAX_WORDS);
  localparam logic [ADDR_W-1:0] AONE = ADDR_W'(1);

  state_t            state;
  logic [31:0]       svc;
  logic [31:0]       arg;
  logic [ADDR_W-1:0] waddr;
  logic [16:0]       wcnt;
  logic [1:0]        bidx;
  logic [31:0]       wbuf;
  logic [7:0]        cur;
  logic              emit_vld;

  // Little-endian byte pick: byte 0 is the first character of the word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction

  assign cur = byte_sel(wbuf, bidx);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      svc   <= '0;
      arg   <= '0;
      waddr <= '0;
      wcnt  <= '0;
      bidx  <= '0;
      wbuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sys_req) begin
            svc <= bus.regv;
            arg <= bus.rega;
            case (bus.regv)
              32'd1:   state <= PUT_INT;
              32'd4: begin
                state <= FETCH;
                waddr <= bus.rega[ADDR_W+1:2];
                wcnt  <= '0;
              end
              32'd10:  state <= HALT;
              default: state <= DONE;
            endcase
          end
        end
        PUT_INT: begin
          if (bus.int_ready) state <= DONE;
        end
        FETCH: begin
          wbuf  <= bus.mem_rdata;
          bidx  <= '0;
          state <= EMIT;
        end
        EMIT: begin
          // A NUL byte ends the string without being offered to the sink.
          if (cur == 8'd0) begin
            state <= NEWLINE;
          end else if (bus.char_ready) begin
            if (bidx != 2'd3) begin
              bidx <= bidx + 2'd1;
            end else begin
              waddr <= waddr + AONE;
              wcnt  <= wcnt + 17'd1;
              // Runaway strings are cut after MAX_WORDS full words.
              if (wcnt + 17'd1 == MAXW) state <= NEWLINE;
              else                      state <= FETCH;
            end
          end
        end
        NEWLINE: begin
          if (bus.char_ready) state <= DONE;
        end
        DONE:    state <= IDLE;
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded purely from registered state, so valid/data stay
  // stable while a sink holds off ready.
  assign emit_vld       = (state == EMIT) && (cur != 8'd0);
  assign bus.mem_sel    = (state == FETCH);
  assign bus.mem_addr   = (state == FETCH) ? waddr : '0;
  assign bus.int_valid  = (state == PUT_INT) && (svc == 32'd1);
  assign bus.int_data   = bus.int_valid ? arg : 32'd0;
  assign bus.char_valid = emit_vld || (state == NEWLINE);
  assign bus.char_data  = emit_vld ? cur : ((state == NEWLINE) ? 8'h0A : 8'h00);
  // Combinational term on sys_req freezes the pipeline in the syscall cycle.
  assign bus.stall      = ((state == IDLE) && bus.sys_req) ||
                          !((state == IDLE) || (state == DONE));
  assign bus.done       = (state == DONE);
  assign bus.halt       = (state == HALT);

endmodule

// File: tb/tb_syscall_ctrl.sv
module tb_syscall_ctrl;
  localparam int AW = 30;
  localparam int MW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  syscall_ctrl_if #(.ADDR_W(AW)) bus();
  syscall_ctrl #(.ADDR_W(AW), .MAX_WORDS(MW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  logic [31:0] mem [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ready generator: 0 = always ready, 1 = char_ready toggles, 2 = random
  int rmode = 0;
  initial begin
    bus.char_ready = 1'b1;
    bus.int_ready  = 1'b1;
    forever begin
      @(negedge clk); #1;
      case (rmode)
        0: begin bus.char_ready = 1'b1; bus.int_ready = 1'b1; end
        1: begin bus.char_ready = ~bus.char_ready; bus.int_ready = 1'b1; end
        default: begin
          bus.char_ready = 1'($urandom_range(0, 1));
          bus.int_ready  = 1'($urandom_range(0, 1));
        end
      endcase
    end
  end

  // sink monitor: records accepted bytes/ints and protocol violations
  logic [7:0]  cq [$];
  logic [31:0] iq [$];
  int viol = 0;
  initial begin
    logic cpend, ipend;
    logic [7:0] cprev;
    logic [31:0] iprev;
    cpend = 0; ipend = 0; cprev = 0; iprev = 0;
    forever begin
      @(negedge clk); #2;
      if (rst_n) begin
        if (bus.char_valid && bus.int_valid) viol++;
        if (cpend && (!bus.char_valid || bus.char_data !== cprev)) viol++;
        if (ipend && (!bus.int_valid || bus.int_data !== iprev)) viol++;
        if (bus.char_valid && bus.char_ready) cq.push_back(bus.char_data);
        if (bus.int_valid && bus.int_ready) iq.push_back(bus.int_data);
        cpend = bus.char_valid && !bus.char_ready;
        ipend = bus.int_valid && !bus.int_ready;
        cprev = bus.char_data;
        iprev = bus.int_data;
      end else begin
        cpend = 0;
        ipend = 0;
      end
    end
  end

  function automatic logic [75:0] outs();
    return {bus.stall, bus.done, bus.halt, bus.char_valid, bus.int_valid, bus.mem_sel,
            bus.mem_addr, bus.char_data, bus.int_data};
  endfunction

  function automatic logic [71:0] packq();
    logic [71:0] p;
    p = '0;
    for (int i = 0; i < cq.size() && i < 9; i++) p[8*i +: 8] = cq[i];
    return p;
  endfunction

  // Reference: what the console should see for a service, and how long it
  // takes with both sinks permanently ready.
  task automatic model(input logic [31:0] v, input logic [31:0] a, output int nb,
                       output logic [71:0] eb, output int ni, output logic [31:0] ei,
                       output int lat);
    int fetches, nz;
    bit hit;
    logic [31:0] wd;
    logic [7:0] by;
    nb = 0; eb = '0; ni = 0; ei = '0; lat = 1;
    fetches = 0; nz = 0; hit = 0;
    if (v == 32'd1) begin
      ni = 1; ei = a; lat = 2;
    end else if (v == 32'd4) begin
      for (int w = 0; w < MW && !hit; w++) begin
        wd = mem[((a >> 2) + w) & 32'hFF];
        fetches++;
        for (int b = 0; b < 4 && !hit; b++) begin
          by = wd[8*b +: 8];
          if (by == 8'd0) hit = 1;
          else begin eb[8*nb +: 8] = by; nb++; nz++; end
        end
      end
      eb[8*nb +: 8] = 8'h0A;
      nb++;
      lat = fetches + nz + (hit ? 1 : 0) + 2;
    end
  endtask

  // Issue one syscall; lat = cycles from the request cycle to done/halt, -1 on timeout.
  task automatic do_sys(input logic [31:0] v, input logic [31:0] a, output int lat,
                        output bit st_ok);
    int c;
    st_ok = 1; lat = -1; c = 0;
    cq.delete(); iq.delete(); viol = 0;
    @(negedge clk); #1;
    bus.sys_req = 1'b1; bus.regv = v; bus.rega = a;
    #2;
    if (bus.stall !== 1'b1) st_ok = 0;
    while (lat < 0 && c < 600) begin
      @(negedge clk); #1;
      bus.sys_req = 1'b0;
      c++;
      #2;
      if (bus.done === 1'b1 || bus.halt === 1'b1) begin
        lat = c;
        if (bus.done === 1'b1 && bus.stall !== 1'b0) st_ok = 0;
      end else if (bus.stall !== 1'b1) st_ok = 0;
    end
  endtask

  typedef struct {
    logic [31:0] v, a, w0, w1, w2;
    int          nb;
    logic [71:0] eb;
    int          ni;
    logic [31:0] ei;
    int          lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int lat, nb, ni, elat, seen;
    bit st;
    logic [71:0] eb;
    logic [31:0] ei, v, a, wd;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.sys_req = 1'b0; bus.regv = '0; bus.rega = '0;

    tbl[0] = '{32'd1, 32'hFFFFFFF6, 0, 0, 0, 0, 72'h0, 1, 32'hFFFFFFF6, 2};
    tbl[1] = '{32'd4, 32'h100, 32'h6C6C6548, 32'h0000006F, 0, 6, 72'h0A6F6C6C6548, 0, 0, 10};
    tbl[2] = '{32'd4, 32'h200, 0, 32'h41414141, 0, 1, 72'h0A, 0, 0, 4};
    tbl[3] = '{32'd4, 32'h300, 32'h41414141, 32'h41414141, 32'h42424242, 9,
               72'h0A4141414141414141, 0, 0, 12};
    tbl[4] = '{32'd7, 32'h1234, 32'h0, 0, 0, 0, 72'h0, 0, 0, 1};
    tbl[5] = '{32'd4, 32'h40, 32'h00434241, 32'h5A5A5A5A, 0, 4, 72'h0A434241, 0, 0, 7};
    tbl[6] = '{32'd4, 32'h107, 32'h00006968, 0, 0, 3, 72'h0A6968, 0, 0, 6};

    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("reset_outputs", outs(), '0);

    // table-driven vectors, sinks always ready
    for (int k = 0; k < 7; k++) begin
      if (tbl[k].v == 32'd4) begin
        mem[((tbl[k].a >> 2) + 0) & 32'hFF] = tbl[k].w0;
        mem[((tbl[k].a >> 2) + 1) & 32'hFF] = tbl[k].w1;
        mem[((tbl[k].a >> 2) + 2) & 32'hFF] = tbl[k].w2;
      end
      do_sys(tbl[k].v, tbl[k].a, lat, st);
      chk($sformatf("tbl%0d_latency", k), lat, tbl[k].lat);
      chk($sformatf("tbl%0d_stall", k), st, 1);
      chk($sformatf("tbl%0d_nbytes", k), cq.size(), tbl[k].nb);
      chk($sformatf("tbl%0d_bytes", k), packq(), tbl[k].eb);
      chk($sformatf("tbl%0d_nints", k), iq.size(), tbl[k].ni);
      if (tbl[k].ni > 0 && iq.size() > 0) chk($sformatf("tbl%0d_int", k), iq[0], tbl[k].ei);
      chk($sformatf("tbl%0d_protocol", k), viol, 0);
    end

    // randomized services against the reference model
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0: v = 32'd1;
        1: v = 32'd4;
        default: v = 32'($urandom_range(11, 60));
      endcase
      a = (v == 32'd1) ? $urandom : 32'($urandom_range(0, 1023));
      if (v == 32'd4) begin
        for (int w = 0; w < MW + 1; w++) begin
          wd = '0;
          for (int b = 0; b < 4; b++)
            wd[8*b +: 8] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
          mem[((a >> 2) + w) & 32'hFF] = wd;
        end
      end
      rmode = (r % 2 == 0) ? 0 : 2;
      model(v, a, nb, eb, ni, ei, elat);
      do_sys(v, a, lat, st);
      chk($sformatf("rnd%0d_complete", r), lat > 0, 1);
      if (rmode == 0) chk($sformatf("rnd%0d_latency", r), lat, elat);
      chk($sformatf("rnd%0d_nbytes", r), cq.size(), nb);
      chk($sformatf("rnd%0d_bytes", r), packq(), eb);
      chk($sformatf("rnd%0d_nints", r), iq.size(), ni);
      if (ni > 0 && iq.size() > 0) chk($sformatf("rnd%0d_int", r), iq[0], ei);
      chk($sformatf("rnd%0d_protocol", r), viol, 0);
    end

    // backpressure: char_ready toggling every cycle
    mem[8'h40] = 32'h6C6C6548;
    mem[8'h41] = 32'h0000006F;
    rmode = 1;
    do_sys(32'd4, 32'h100, lat, st);
    chk("bp_complete", lat > 10, 1);
    chk("bp_nbytes", cq.size(), 6);
    chk("bp_bytes", packq(), 72'h0A6F6C6C6548);
    chk("bp_protocol", viol, 0);
    rmode = 0;
    repeat (2) @(negedge clk);

    // reset during the third EMIT of "Hello"
    cq.delete(); iq.delete();
    @(negedge clk); #1;
    bus.sys_req = 1'b1; bus.regv = 32'd4; bus.rega = 32'h100;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); #1;
      bus.sys_req = 1'b0;
      if (c == 4) rst_n = 1'b0;
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1 chk("midrst_outputs", outs(), '0);
    repeat (4) @(negedge clk);
    chk("midrst_nbytes", cq.size(), 2);
    chk("midrst_bytes", packq(), 72'h6548);
    do_sys(32'd1, 32'h12345678, lat, st);
    chk("midrst_int_latency", lat, 2);
    chk("midrst_int_value", (iq.size() == 1) ? iq[0] : 32'hDEADBEEF, 32'h12345678);

    // exit: sticky halt, later requests ignored, reset clears it
    do_sys(32'd10, 32'h0, lat, st);
    chk("exit_latency", lat, 1);
    chk("exit_stall_T", st, 1);
    repeat (3) @(negedge clk);
    #3 chk("halt_sticky", {bus.halt, bus.stall, bus.done}, 3'b110);
    cq.delete(); iq.delete();
    @(negedge clk); #1;
    bus.sys_req = 1'b1; bus.regv = 32'd1; bus.rega = 32'h55;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      bus.sys_req = 1'b0;
      #1;
      if (bus.done || bus.int_valid || bus.char_valid || !bus.halt || !bus.stall) seen++;
    end
    chk("halt_ignores_req", seen, 0);
    chk("halt_no_output", cq.size() + iq.size(), 0);
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    #1 chk("halt_cleared", outs(), '0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
